// File: rtl/decpt_bin_pkg.sv
// ---------------------------------------------------------------------------
// decpt_bin_pkg
// Shared definitions for the decpt_bin down-counter timer. The state
// encodings are fixed (IDLE=0, RUN=1, EXPIRED=2) so the testbench can import
// the same names as the RTL.
// ---------------------------------------------------------------------------
package decpt_bin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

endpackage

// File: rtl/decpt_bin_dec_bin.sv
// ---------------------------------------------------------------------------
// dec_bin
// Combinational decrement datapath for the decpt_bin timer.
// Ports:
//   i_val    [SIZE-1:0]  value to decrement
//   o_dec    [SIZE-1:0]  i_val - 1 (the caller never uses it when i_val == 0)
//   o_is_one             high when i_val == 1, i.e. the next active edge expires
// ---------------------------------------------------------------------------
module dec_bin #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] i_val,
    output logic [SIZE-1:0] o_dec,
    output logic            o_is_one
);

    localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

    assign o_dec    = i_val - ONE;
    assign o_is_one = (i_val == ONE);

endmodule

// File: rtl/decpt_bin.sv
// ---------------------------------------------------------------------------
// decpt_bin
// Loadable binary down-counter (timer) with IDLE / RUN / EXPIRED states and
// an optional auto-reload of the last loaded value at expiry.
// Ports:
//   clk       clock, all state updates on the rising edge
//   reset     asynchronous active-high reset
//   activate  count enable in RUN; in EXPIRED, low returns to IDLE
//   load      captures val on the next edge (has priority over counting)
//   reload    at expiry: 1 = restart from saved value, 0 = go to EXPIRED
//   val       [SIZE-1:0] start value
//   cpt       [SIZE-1:0] current count (registered)
//   busy      high while in RUN (registered)
//   done      one-cycle pulse on the expiry edge (registered)
// ---------------------------------------------------------------------------
module decpt_bin
    import decpt_bin_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            activate,
    input  logic            load,
    input  logic            reload,
    input  logic [SIZE-1:0] val,
    output logic [SIZE-1:0] cpt,
    output logic            busy,
    output logic            done
);

    localparam logic [SIZE-1:0] ZERO = {SIZE{1'b0}};

    state_t          r_state;
    logic [SIZE-1:0] r_cpt;
    logic [SIZE-1:0] r_saved;
    logic            r_busy;
    logic            r_done;

    state_t          w_state_nx;
    logic [SIZE-1:0] w_cpt_nx;
    logic [SIZE-1:0] w_saved_nx;
    logic            w_done_nx;
    logic [SIZE-1:0] w_dec;
    logic            w_is_one;

    dec_bin #(
        .SIZE (SIZE)
    ) u_dec (
        .i_val    (r_cpt),
        .o_dec    (w_dec),
        .o_is_one (w_is_one)
    );

    // Next-state, next-count and done-pulse decision; load overrides everything.
    always_comb begin
        w_state_nx = r_state;
        w_cpt_nx   = r_cpt;
        w_saved_nx = r_saved;
        w_done_nx  = 1'b0;
        if (load) begin
            if (val != ZERO) begin
                w_cpt_nx   = val;
                w_saved_nx = val;
                w_state_nx = ST_RUN;
            end else begin
                w_cpt_nx   = ZERO;
                w_state_nx = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_IDLE;
                end
                ST_RUN: begin
                    if (activate) begin
                        if (w_is_one) begin
                            w_done_nx = 1'b1;
                            if (reload) begin
                                w_cpt_nx = r_saved;
                            end else begin
                                w_cpt_nx   = ZERO;
                                w_state_nx = ST_EXPIRED;
                            end
                        end else if (r_cpt != ZERO) begin
                            w_cpt_nx = w_dec;
                        end else begin
                            // Never decrement from zero, whatever got us here.
                            w_cpt_nx = ZERO;
                        end
                    end else begin
                        w_cpt_nx = r_cpt;
                    end
                end
                ST_EXPIRED: begin
                    w_cpt_nx = ZERO;
                    if (!activate) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_state_nx = ST_EXPIRED;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cpt_nx   = ZERO;
                end
            endcase
        end
    end

    // State, count, saved value and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cpt   <= ZERO;
            r_saved <= ZERO;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cpt   <= w_cpt_nx;
            r_saved <= w_saved_nx;
            r_busy  <= (w_state_nx == ST_RUN);
            r_done  <= w_done_nx;
        end
    end

    assign cpt  = r_cpt;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_decpt_bin.sv
module tb_decpt_bin;
    import decpt_bin_pkg::*;

    localparam int SIZE = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            activate;
    logic            load;
    logic            reload;
    logic [SIZE-1:0] val;
    logic [SIZE-1:0] cpt;
    logic            busy;
    logic            done;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: timer behaviour in plain integers.
    state_t m_st;
    int     m_cnt;
    int     m_saved;
    int     m_done;

    decpt_bin #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .reset    (reset),
        .activate (activate),
        .load     (load),
        .reload   (reload),
        .val      (val),
        .cpt      (cpt),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic l, input int v, input logic a, input logic r);
        load     = l;
        val      = v[SIZE-1:0];
        activate = a;
        reload   = r;
    endtask

    task automatic model_reset();
        m_st    = ST_IDLE;
        m_cnt   = 0;
        m_saved = 0;
        m_done  = 0;
    endtask

    // One clock: the model consumes the inputs seen at the edge, then outputs
    // are compared at the following falling edge.
    task automatic step();
        @(posedge clk);
        m_done = 0;
        if (load) begin
            if (val != 0) begin
                m_cnt = val; m_saved = val; m_st = ST_RUN;
            end else begin
                m_cnt = 0; m_st = ST_IDLE;
            end
        end else if (m_st == ST_RUN && activate) begin
            if (m_cnt == 1) begin
                m_done = 1;
                if (reload) m_cnt = m_saved;
                else begin m_cnt = 0; m_st = ST_EXPIRED; end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end else if (m_st == ST_EXPIRED && !activate) begin
            m_st = ST_IDLE;
        end
        @(negedge clk);
        check_eq("cpt",  int'(cpt),  m_cnt);
        check_eq("busy", int'(busy), (m_st == ST_RUN) ? 1 : 0);
        check_eq("done", int'(done), m_done);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("rst_cpt",  int'(cpt),  0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int dones;
        int act_edges;
        int prev;
        int seen_done;
        reset = 1'b0;
        set_in(1'b0, 0, 1'b0, 1'b0);
        model_reset();

        do_reset();

        // Reset then load 5: 5,4,3,2,1,0 with done on the last edge.
        set_in(1'b1, 5, 1'b1, 1'b0);
        step();
        check_eq("r30_load", int'(cpt), 5);
        set_in(1'b0, 0, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_eq("r30_seq",  int'(cpt),  5 - k);
            check_eq("r30_done", int'(done), (k == 5) ? 1 : 0);
        end
        check_eq("r30_busy", int'(busy), 0);
        step();                              // still EXPIRED while activate=1
        set_in(1'b0, 0, 1'b0, 1'b0);
        step();                              // back to IDLE

        // Auto-reload of 3: done every 3 edges, busy stays high.
        set_in(1'b1, 3, 1'b1, 1'b1);
        step();
        set_in(1'b0, 0, 1'b1, 1'b1);
        dones = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            dones += int'(done);
            check_eq("r31_cpt",  int'(cpt),  3 - (k % 3));
            check_eq("r31_busy", int'(busy), 1);
        end
        check_eq("r31_dones", dones, 3);

        // Load 200 with activate toggling every 2 cycles.
        set_in(1'b1, 200, 1'b0, 1'b0);
        step();
        act_edges = 0;
        seen_done = 0;
        prev = int'(cpt);
        for (int k = 0; k < 1000 && seen_done == 0; k++) begin
            set_in(1'b0, 0, ((k / 2) % 2) == 1, 1'b0);
            step();
            if (activate) begin
                act_edges++;
                check_eq("r32_no_repeat", (int'(cpt) != prev) ? 1 : 0, 1);
            end else begin
                check_eq("r32_hold", int'(cpt), prev);
            end
            prev = int'(cpt);
            if (done) seen_done = 1;
        end
        check_eq("r32_seen_done", seen_done, 1);
        check_eq("r32_active_edges", act_edges, 200);
        set_in(1'b0, 0, 1'b0, 1'b0);
        step();

        // Load wins over the cpt==1 expiry.
        set_in(1'b1, 2, 1'b1, 1'b0);
        step();
        set_in(1'b0, 0, 1'b1, 1'b0);
        step();
        check_eq("r33_pre", int'(cpt), 1);
        set_in(1'b1, 9, 1'b1, 1'b0);
        step();
        check_eq("r33_cpt",  int'(cpt),  9);
        check_eq("r33_done", int'(done), 0);
        check_eq("r33_busy", int'(busy), 1);

        // Asynchronous reset mid-cycle at cpt=4.
        set_in(1'b1, 6, 1'b1, 1'b0);
        step();
        set_in(1'b0, 0, 1'b1, 1'b0);
        step();
        step();
        check_eq("r34_pre", int'(cpt), 4);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("r34_cpt",  int'(cpt),  0);
        check_eq("r34_busy", int'(busy), 0);
        check_eq("r34_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();                          // activate ignored until load
            check_eq("r26_idle", int'(cpt), 0);
        end

        // Load 0 goes to IDLE without done; 255 counts down without wrap.
        set_in(1'b1, 0, 1'b1, 1'b0);
        step();
        check_eq("r35_zero_busy", int'(busy), 0);
        set_in(1'b1, 255, 1'b1, 1'b0);
        step();
        set_in(1'b0, 0, 1'b1, 1'b0);
        dones = 0;
        for (int k = 1; k <= 255; k++) begin
            step();
            dones += int'(done);
        end
        check_eq("r35_end_cpt", int'(cpt),  0);
        check_eq("r35_end_done", int'(done), 1);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("r35_no_wrap", int'(cpt), 0);
        end
        check_eq("r35_dones", dones, 1);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            int v;
            v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
            set_in($urandom_range(0, 9) == 0, v, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1) == 1);
            step();
            if (k == 300) do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
